// File: rtl/lsu_dccm_bank_arb.sv
// DCCM port controller for the LSU DC1->DC2->DC3 pipe.
// Each cycle it decides whether a store-buffer write or a DC1 load read gets
// the DCCM banks. It carries the read through DC2 to DC3. There it merges the
// store-buffer forwarding bytes into the read data and right-justifies the
// load result.
// Optional feature macro: RV_LSU_STBUF_STARVE_EN. When it is defined, a
// starvation counter forces a store commit after STARVE_MAX consecutive
// losses, and it stalls the DC1 load to make room for that commit.

// One byte lane of the forwarding merge.
module lsu_dccm_byte_mux (
    input  logic       fwd_en,
    input  logic [7:0] fwd_byte,
    input  logic [7:0] rd_byte,
    output logic [7:0] merged_byte
);
    assign merged_byte = fwd_en ? fwd_byte : rd_byte;
endmodule

module lsu_dccm_bank_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ECC_WIDTH  = 7,
    parameter int ADDR_BITS  = 16,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_LO    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                                clk,
    input  logic                                rst_l,
    input  logic                                freeze,
    input  logic                                ld_valid_dc1,
    input  logic [ADDR_BITS-1:0]                ld_addr_dc1,
    input  logic [ADDR_BITS-1:0]                ld_end_addr_dc1,
    input  logic                                st_req,
    input  logic [ADDR_BITS-1:0]                st_addr,
    input  logic [DATA_WIDTH-1:0]               st_data,
    input  logic [ECC_WIDTH-1:0]                st_ecc,
    input  logic [2*DATA_WIDTH/8-1:0]           fwd_byteen_dc3,
    input  logic [2*DATA_WIDTH-1:0]             fwd_data_dc3,
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0]     dccm_rd_data_lo,
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0]     dccm_rd_data_hi,
    output logic                                st_commit,
    output logic                                ld_stall_dc1,
    output logic                                dccm_wren,
    output logic [ADDR_BITS-1:0]                dccm_wr_addr,
    output logic [DATA_WIDTH+ECC_WIDTH-1:0]     dccm_wr_data,
    output logic                                dccm_rden,
    output logic [ADDR_BITS-1:0]                dccm_rd_addr_lo,
    output logic [ADDR_BITS-1:0]                dccm_rd_addr_hi,
    output logic                                rden_dc3,
    output logic [2*(DATA_WIDTH+ECC_WIDTH)-1:0] data_ecc_dc3,
    output logic [DATA_WIDTH-1:0]               ld_data_dc3
);
    localparam int BB  = $clog2(NUM_BANKS);
    localparam int DWE = DATA_WIDTH + ECC_WIDTH;
    localparam int NB  = DATA_WIDTH / 8;
    // The offset register stays at least one bit wide. This covers byte-wide banks, where BANK_LO is 0.
    localparam int OW  = (BANK_LO > 0) ? BANK_LO : 1;

    logic [BB-1:0] st_bank, ld_bank_lo, ld_bank_hi;
    logic          conflict, force_commit;
    logic [2:1]    vld_pipe;       // [1] = rden_dc2, [2] = rden_dc3
    logic [OW-1:0] off_dc1, off_dc2, off_dc3;
    logic [2*DATA_WIDTH-1:0] raw_data, merged;

    assign st_bank    = st_addr[BANK_LO +: BB];
    assign ld_bank_lo = ld_addr_dc1[BANK_LO +: BB];
    assign ld_bank_hi = ld_end_addr_dc1[BANK_LO +: BB];

    // An unaligned load touches the bank of its start address and the bank of its end address.
    assign conflict = ld_valid_dc1 & st_req &
                      ((st_bank == ld_bank_lo) | (st_bank == ld_bank_hi));

`ifdef RV_LSU_STBUF_STARVE_EN
    logic [3:0] starve_cnt;

    assign force_commit = (starve_cnt == 4'(STARVE_MAX));

    // Count consecutive lost store cycles and saturate at the force threshold.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            starve_cnt <= '0;
        else if (!freeze) begin
            if (!st_req || st_commit)
                starve_cnt <= '0;
            else if (starve_cnt != 4'(STARVE_MAX))
                starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign force_commit = 1'b0;
`endif

    assign st_commit    = st_req & ~freeze & (~conflict | force_commit);
    assign ld_stall_dc1 = ld_valid_dc1 & force_commit & conflict & ~freeze;
    assign dccm_wren    = st_commit;
    assign dccm_wr_addr = st_addr;
    assign dccm_wr_data = {st_ecc, st_data};
    assign dccm_rden    = ld_valid_dc1 & ~ld_stall_dc1;
    assign dccm_rd_addr_lo = ld_addr_dc1;
    assign dccm_rd_addr_hi = ld_end_addr_dc1;

    generate
        if (BANK_LO > 0) begin : g_off
            assign off_dc1 = ld_addr_dc1[OW-1:0];
        end else begin : g_no_off
            assign off_dc1 = '0;
        end
    endgenerate

    // Move the read-valid and byte offset down the pipe. Both hold while the pipe is frozen.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            vld_pipe <= '0;
            off_dc2  <= '0;
            off_dc3  <= '0;
        end else if (!freeze) begin
            vld_pipe <= {vld_pipe[1], dccm_rden};
            off_dc2  <= off_dc1;
            off_dc3  <= off_dc2;
        end
    end

    // Capture the raw bank data, ECC included, only when a read is in DC2.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            data_ecc_dc3 <= '0;
        else if (vld_pipe[1] && !freeze)
            data_ecc_dc3 <= {dccm_rd_data_hi, dccm_rd_data_lo};
    end

    assign rden_dc3 = vld_pipe[2];

    // Remove the ECC bits and lay the data out as {hi, lo} bytes.
    assign raw_data = {data_ecc_dc3[DWE +: DATA_WIDTH], data_ecc_dc3[0 +: DATA_WIDTH]};

    generate
        for (genvar i = 0; i < 2*NB; i++) begin : g_byte
            lsu_dccm_byte_mux u_mux (
                .fwd_en      (fwd_byteen_dc3[i]),
                .fwd_byte    (fwd_data_dc3[8*i +: 8]),
                .rd_byte     (raw_data[8*i +: 8]),
                .merged_byte (merged[8*i +: 8])
            );
        end
    endgenerate

    // Right-justify the merged data from the load's start byte.
    assign ld_data_dc3 = DATA_WIDTH'(merged >> {off_dc3, 3'b000});

endmodule

// File: tb/tb_lsu_dccm_bank_arb.sv
// Self-checking bench for lsu_dccm_bank_arb. Directed cases pin literal
// values. A behavioural model checks every output on every cycle under
// random traffic. Build with +define+RV_LSU_STBUF_STARVE_EN to exercise
// the forced-commit path.
module tb_lsu_dccm_bank_arb;
    localparam int DW = 32, EW = 7, AB = 16, NBK = 4, BLO = 2, SM = 4;
    localparam int DWE = DW + EW, NB = DW / 8;

    logic clk = 0, rst_l = 0, freeze = 0, ld_valid_dc1 = 0, st_req = 0;
    logic [AB-1:0] ld_addr_dc1 = '0, ld_end_addr_dc1 = '0, st_addr = '0;
    logic [DW-1:0] st_data = '0;
    logic [EW-1:0] st_ecc = '0;
    logic [2*NB-1:0] fwd_byteen_dc3 = '0;
    logic [2*DW-1:0] fwd_data_dc3 = '0;
    logic [DWE-1:0] dccm_rd_data_lo = '0, dccm_rd_data_hi = '0;
    logic st_commit, ld_stall_dc1, dccm_wren, dccm_rden, rden_dc3;
    logic [AB-1:0] dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi;
    logic [DWE-1:0] dccm_wr_data;
    logic [2*DWE-1:0] data_ecc_dc3;
    logic [DW-1:0] ld_data_dc3;

    int n_cmp = 0, n_bad = 0;

    lsu_dccm_bank_arb #(.DATA_WIDTH(DW), .ECC_WIDTH(EW), .ADDR_BITS(AB),
        .NUM_BANKS(NBK), .BANK_LO(BLO), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_l(rst_l), .freeze(freeze),
        .ld_valid_dc1(ld_valid_dc1), .ld_addr_dc1(ld_addr_dc1),
        .ld_end_addr_dc1(ld_end_addr_dc1), .st_req(st_req), .st_addr(st_addr),
        .st_data(st_data), .st_ecc(st_ecc), .fwd_byteen_dc3(fwd_byteen_dc3),
        .fwd_data_dc3(fwd_data_dc3), .dccm_rd_data_lo(dccm_rd_data_lo),
        .dccm_rd_data_hi(dccm_rd_data_hi), .st_commit(st_commit),
        .ld_stall_dc1(ld_stall_dc1), .dccm_wren(dccm_wren),
        .dccm_wr_addr(dccm_wr_addr), .dccm_wr_data(dccm_wr_data),
        .dccm_rden(dccm_rden), .dccm_rd_addr_lo(dccm_rd_addr_lo),
        .dccm_rd_addr_hi(dccm_rd_addr_hi), .rden_dc3(rden_dc3),
        .data_ecc_dc3(data_ecc_dc3), .ld_data_dc3(ld_data_dc3));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int bank_of(input int a);
        return (a / NB) % NBK;
    endfunction

    // Build the expected load result one byte at a time from the load's start offset.
    function automatic logic [DW-1:0] exp_ld(input logic [2*DWE-1:0] raw,
            input logic [2*NB-1:0] be, input logic [2*DW-1:0] fd, input int off);
        logic [7:0] b [2*NB];
        logic [DW-1:0] r;
        for (int i = 0; i < 2*NB; i++)
            b[i] = be[i] ? fd[8*i +: 8] :
                   (i < NB) ? raw[8*i +: 8] : raw[DWE + 8*(i-NB) +: 8];
        r = '0;
        for (int j = 0; j < NB; j++)
            if (j + off < 2*NB) r[8*j +: 8] = b[j+off];
        return r;
    endfunction

    // Model state. rq and oq keep the read-valid and start offset of the
    // most recent unfrozen cycles, newest first. m_raw is the last read
    // data that reached DC3.
    bit rq [$] = '{0, 0};
    int oq [$] = '{0, 0};
    logic [2*DWE-1:0] m_raw = '0;
    int m_cnt = 0;

    // Check every DUT output against the model each cycle, then advance the model.
    always @(negedge clk) begin
        bit cf, fc, e_commit, e_stall, e_rden;
        int sb;
        if (!rst_l) begin
            rq = '{0, 0}; oq = '{0, 0}; m_raw = '0; m_cnt = 0;
        end
        sb = bank_of(int'(st_addr));
        cf = ld_valid_dc1 && st_req &&
             (sb == bank_of(int'(ld_addr_dc1)) || sb == bank_of(int'(ld_end_addr_dc1)));
`ifdef RV_LSU_STBUF_STARVE_EN
        fc = (m_cnt == SM);
`else
        fc = 0;
`endif
        e_commit = st_req && !freeze && (!cf || fc);
        e_stall  = ld_valid_dc1 && fc && cf && !freeze;
        e_rden   = ld_valid_dc1 && !e_stall;
        chk("st_commit", 128'(st_commit), 128'(e_commit));
        chk("dccm_wren", 128'(dccm_wren), 128'(e_commit));
        chk("ld_stall", 128'(ld_stall_dc1), 128'(e_stall));
        chk("dccm_rden", 128'(dccm_rden), 128'(e_rden));
        chk("wr_addr", 128'(dccm_wr_addr), 128'(st_addr));
        chk("wr_data", 128'(dccm_wr_data), 128'({st_ecc, st_data}));
        chk("rd_addr_lo", 128'(dccm_rd_addr_lo), 128'(ld_addr_dc1));
        chk("rd_addr_hi", 128'(dccm_rd_addr_hi), 128'(ld_end_addr_dc1));
        chk("rden_dc3", 128'(rden_dc3), 128'(rq[1]));
        chk("data_ecc_dc3", 128'(data_ecc_dc3), 128'(m_raw));
        chk("ld_data_dc3", 128'(ld_data_dc3),
            128'(exp_ld(m_raw, fwd_byteen_dc3, fwd_data_dc3, oq[1])));
        if (rst_l && !freeze) begin
            if (rq[0]) m_raw = {dccm_rd_data_hi, dccm_rd_data_lo};
            rq.push_front(e_rden); void'(rq.pop_back());
            oq.push_front(int'(ld_addr_dc1) % NB); void'(oq.pop_back());
            if (!st_req || e_commit) m_cnt = 0;
            else if (m_cnt < SM) m_cnt++;
        end
    end

    task automatic idle();
        ld_valid_dc1 = 0; st_req = 0; freeze = 0;
        fwd_byteen_dc3 = '0; fwd_data_dc3 = '0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_rden_dc3", 128'(rden_dc3), 128'(0));
        chk("rst_data_ecc", 128'(data_ecc_dc3), 128'(0));
        chk("rst_ld_data", 128'(ld_data_dc3), 128'(0));
        chk("rst_st_commit", 128'(st_commit), 128'(0));
        tick(); rst_l = 1;

        // Store to bank 1 and aligned load from bank 2 share the cycle.
        tick();
        st_req = 1; st_addr = 16'h0004; st_data = 32'hCAFEF00D; st_ecc = 7'h11;
        ld_valid_dc1 = 1; ld_addr_dc1 = 16'h0008; ld_end_addr_dc1 = 16'h000B;
        @(negedge clk);
        chk("t2_commit", 128'(st_commit), 128'(1));
        chk("t2_rden", 128'(dccm_rden), 128'(1));
        chk("t2_wr_data", 128'(dccm_wr_data), 128'({7'h11, 32'hCAFEF00D}));
        tick(); idle();
        dccm_rd_data_lo = {7'h03, 32'hDDCCBBAA}; dccm_rd_data_hi = {7'h04, 32'h11111111};
        tick();
        @(negedge clk);
        chk("t2_rden_dc3", 128'(rden_dc3), 128'(1));
        chk("t2_ld_data", 128'(ld_data_dc3), 128'(32'hDDCCBBAA));

        // Unaligned load spans banks 1 and 2, so the store to bank 2 loses.
        ld_valid_dc1 = 1; ld_addr_dc1 = 16'h0006; ld_end_addr_dc1 = 16'h0009;
        st_req = 1; st_addr = 16'h0008;
        @(negedge clk);
        chk("t3_commit", 128'(st_commit), 128'(0));
        chk("t3_rden", 128'(dccm_rden), 128'(1));
        chk("t3_stall", 128'(ld_stall_dc1), 128'(0));

        // Forwarding merge with an offset of 1.
        tick(); idle();
        ld_valid_dc1 = 1; ld_addr_dc1 = 16'h0001; ld_end_addr_dc1 = 16'h0004;
        tick(); idle();
        dccm_rd_data_lo = {7'h15, 32'h44332211}; dccm_rd_data_hi = {7'h2A, 32'h88776655};
        tick();
        fwd_byteen_dc3 = 8'h04; fwd_data_dc3 = 64'h0000_0000_00AA_0000;
        @(negedge clk);
        chk("t5_ld_data", 128'(ld_data_dc3), 128'(32'h5544AA22));
        chk("t5_data_ecc", 128'(data_ecc_dc3),
            128'({7'h2A, 32'h88776655, 7'h15, 32'h44332211}));

        // Freeze holds DC3 state while a second read waits in DC2.
        tick(); idle();
        ld_valid_dc1 = 1; ld_addr_dc1 = 16'h0000; ld_end_addr_dc1 = 16'h0003;
        tick();
        ld_addr_dc1 = 16'h0002; ld_end_addr_dc1 = 16'h0005;
        dccm_rd_data_lo = {7'h01, 32'h01020304}; dccm_rd_data_hi = {7'h02, 32'h05060708};
        tick(); idle();
        freeze = 1; st_req = 1; st_addr = 16'h0010;
        dccm_rd_data_lo = '1; dccm_rd_data_hi = '1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_commit", 128'(st_commit), 128'(0));
            chk("t6_rden_dc3", 128'(rden_dc3), 128'(1));
            chk("t6_data_ecc", 128'(data_ecc_dc3),
                128'({7'h02, 32'h05060708, 7'h01, 32'h01020304}));
            tick();
        end
        freeze = 0; st_req = 0;
        dccm_rd_data_lo = {7'h05, 32'hA1A2A3A4}; dccm_rd_data_hi = {7'h06, 32'hB1B2B3B4};
        tick();
        @(negedge clk);
        chk("t6_resume_data", 128'(data_ecc_dc3),
            128'({7'h06, 32'hB1B2B3B4, 7'h05, 32'hA1A2A3A4}));
        chk("t6_resume_ld", 128'(ld_data_dc3), 128'(32'hB3B4A1A2));
        tick();
        @(negedge clk);
        chk("t6_drain", 128'(rden_dc3), 128'(0));

        // Reset while a read is in flight.
        tick(); idle();
        ld_valid_dc1 = 1; ld_addr_dc1 = 16'h0000; ld_end_addr_dc1 = 16'h0003;
        tick(); idle();
        dccm_rd_data_lo = {7'h09, 32'h12345678};
        tick();
        rst_l = 0;
        @(negedge clk);
        chk("t1_rden_dc3", 128'(rden_dc3), 128'(0));
        chk("t1_data_ecc", 128'(data_ecc_dc3), 128'(0));
        chk("t1_commit", 128'(st_commit), 128'(0));
        tick(); rst_l = 1;

`ifdef RV_LSU_STBUF_STARVE_EN
        // After STARVE_MAX lost cycles the store is forced and the load stalls.
        tick();
        st_req = 1; st_addr = 16'h0004;
        ld_valid_dc1 = 1; ld_addr_dc1 = 16'h0004; ld_end_addr_dc1 = 16'h0007;
        for (int k = 0; k < SM; k++) begin
            @(negedge clk);
            chk("t4_lose", 128'(st_commit), 128'(0));
            tick();
        end
        @(negedge clk);
        chk("t4_force", 128'(st_commit), 128'(1));
        chk("t4_stall", 128'(ld_stall_dc1), 128'(1));
        chk("t4_rden", 128'(dccm_rden), 128'(0));
        tick();
        @(negedge clk);
        chk("t4_cnt_clr", 128'(st_commit), 128'(0));
`endif

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            int sz;
            tick();
            rst_l = ($urandom_range(0, 299) != 0);
            freeze = ($urandom_range(0, 7) == 0);
            ld_valid_dc1 = ($urandom_range(0, 9) < 7);
            st_req = ($urandom_range(0, 9) < 6);
            ld_addr_dc1 = AB'($urandom_range(0, 63));
            sz = 1 << $urandom_range(0, 2);
            ld_end_addr_dc1 = ld_addr_dc1 + AB'(sz - 1);
            st_addr = AB'($urandom_range(0, 15) * 4);
            st_data = $urandom; st_ecc = EW'($urandom);
            dccm_rd_data_lo = {EW'($urandom), 32'($urandom)};
            dccm_rd_data_hi = {EW'($urandom), 32'($urandom)};
            fwd_byteen_dc3 = ($urandom_range(0, 1) == 0) ? '0 : 8'($urandom);
            fwd_data_dc3 = {32'($urandom), 32'($urandom)};
        end
        tick(); idle(); rst_l = 1;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
